serial_add_ctrl: RTL and testbench

Bit-serial addition controller. It sequences a single one-bit full-adder slice over WIDTH cycles to add two captured operands, LSB first. A carry flip-flop links successive bits. It is the area-minimal alternative to a WIDTH-bit ripple adder, and it talks to its client over a start/done handshake.

---
 rtl/serial_add_pkg.sv | 18 +
 rtl/serial_add_ctrl_fa_slice.sv | 16 +
 rtl/serial_add_ctrl.sv | 138 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// Used by serial_add_ctrl; see that file for the SERIAL_ADD_SUB_EN option.
package serial_add_pkg;

    localparam int unsigned WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Bit counter width; at least one bit so the counter stays a legal vector.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_slice.sv
// Combinational one-bit full adder shared by every bit position of the serial add.
module fa_slice (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_c
);

    logic w_p;

    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_cin;
    assign o_c = (i_a & i_b) | (i_cin & w_p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice stepped over WIDTH cycles, LSB first.
// Define SERIAL_ADD_SUB_EN to add the sub port (a - b via ~b plus carry-in of 1).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
        $error("serial_add_ctrl: WIDTH must be in 2..64");
    end

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   w_op_a_nxt;
    logic [WIDTH-1:0]   r_op_b;
    logic [WIDTH-1:0]   w_op_b_nxt;
    logic               r_carry;
    logic               w_carry_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   r_sum;
    logic [WIDTH-1:0]   w_sum_nxt;
    logic               r_cout;
    logic               w_cout_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;
    logic               w_s;
    logic               w_c;

    fa_slice u_fa (
        .i_a   (r_op_a[0]),
        .i_b   (r_op_b[0]),
        .i_cin (r_carry),
        .o_s   (w_s),
        .o_c   (w_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op_a  <= w_op_a_nxt;
            r_op_b  <= w_op_b_nxt;
            r_carry <= w_carry_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sum   <= w_sum_nxt;
            r_cout  <= w_cout_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_a_nxt  = r_op_a;
        w_op_b_nxt  = r_op_b;
        w_carry_nxt = r_carry;
        w_cnt_nxt   = r_cnt;
        w_sum_nxt   = r_sum;
        w_cout_nxt  = r_cout;
        w_ovf_nxt   = r_ovf;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_op_a_nxt  = a;
                    w_op_b_nxt  = b;
                    w_carry_nxt = cin;
`ifdef SERIAL_ADD_SUB_EN
                    if (sub) begin
                        w_op_b_nxt  = ~b;
                        w_carry_nxt = 1'b1;
                    end
`endif
                    w_cnt_nxt   = '0;
                    w_sum_nxt   = '0;
                    w_cout_nxt  = 1'b0;
                    w_ovf_nxt   = 1'b0;
                end
            end
            ST_RUN: begin
                w_sum_nxt   = {w_s, r_sum[WIDTH-1:1]};
                w_op_a_nxt  = r_op_a >> 1;
                w_op_b_nxt  = r_op_b >> 1;
                w_carry_nxt = w_c;
                if (r_cnt == CNT_LAST) begin
                    // r_carry here is the carry into the MSB.
                    w_cout_nxt  = w_c;
                    w_ovf_nxt   = r_carry ^ w_c;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: directed cases plus random operands.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cycle = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cycle);
    endtask

    // Reference: plain integer arithmetic on the effective operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        exp_t         e;
        logic [W-1:0] yy;
        logic         c0;
        logic [W:0]   full;
        yy     = s ? ~y : y;
        c0     = s ? 1'b1 : c;
        full   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c0};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            if (q.size() == 0) begin
                chk("spurious_done", done, 0);
            end else begin
                e = q.pop_front();
                chk("sum", sum, e.sum);
                chk("cout", cout, e.cout);
                chk("ovf", ovf, e.ovf);
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b,
                          input logic tc, input logic ts, input bit poke);
        int n;
        int nb;
        @(negedge clk);
        a = ta; b = tb_b; cin = tc; sub = ts; start = 1'b1;
        q.push_back(model(ta, tb_b, tc, ts));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        n = 0;
        nb = 0;
        while (!done && n < 4 * W) begin
            if (busy) nb++;
            if (poke && n == 3) begin
                start = 1'b1; a = 1; b = 1;
            end else begin
                start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_latency", n, W);
        chk("busy_cycles", nb, W);
        chk("busy_at_done", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t cur;
        int   prev;
        int   n;
        logic s_en;
`ifdef SERIAL_ADD_SUB_EN
        s_en = 1'b1;
`else
        s_en = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;

        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
`endif

        // Abort mid-operation with an asynchronous reset.
        @(negedge clk);
        a = 8'h55; b = 8'hAA; cin = 1'b0; sub = 1'b0; start = 1'b1;
        q.push_back(model(8'h55, 8'hAA, 1'b0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_sum", sum, 0);
        chk("arst_cout", cout, 0);
        chk("arst_ovf", ovf, 0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        chk("no_done_after_arst", done, 0);
        run_op(8'h03, 8'h04, 1'b0, 1'b0, 1'b0);

        // Start held high: back-to-back accepts every W+2 cycles.
        @(negedge clk);
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = s_en & 1'($urandom);
        start = 1'b1;
        cur = model(a, b, cin, sub);
        q.push_back(cur);
        prev = -1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!done && n < 4 * W) begin
                n++;
                @(negedge clk);
            end
            chk("held_done_seen", done, 1);
            if (prev >= 0) chk("issue_interval", cycle - prev, W + 2);
            prev = cycle;
            if (k < 3) begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                sub = s_en & 1'($urandom);
                q.push_back(model(a, b, cin, sub));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            chk("held_sum_stable", sum, cur.sum);
            chk("held_cout_stable", cout, cur.cout);
            if (k < 3) cur = q[0];
        end

        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), s_en & 1'($urandom), 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
